// File: rtl/seg7_display_monitor.sv
// Receive-side monitor for a seven-segment seconds counter: filters the
// segment bus, decodes digits, checks 0..9 stepping and measures the period.
module seg7_display_monitor #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       seg_in,
  input  logic             clear_errors,
  output logic [3:0]       digit,
  output logic             digit_valid,
  output logic             new_digit,
  output logic             seq_error,
  output logic             invalid_pattern,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic [7:0]       error_count
);

  localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [SW-1:0]    STAB_MAX = SW'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    TRACK = 2'd2
  } state_t;

  logic [6:0]       sync1_q;
  logic [6:0]       seg_s_q;
  logic [6:0]       cand_q;
  logic [SW-1:0]    stab_q;
  logic [6:0]       acc_q;
  state_t           state_q;
  logic [CNT_W-1:0] pcnt_q;
  logic [3:0]       digit_q;
  logic             digit_valid_q;
  logic             new_digit_q;
  logic             seq_error_q;
  logic             invalid_q;
  logic [CNT_W-1:0] period_q;
  logic             period_valid_q;
  logic [7:0]       err_cnt_q;
  logic [7:0]       err_cnt_d;

  logic       dec_ok;
  logic [3:0] dec_digit;
  logic       accept;
  logic       acc_valid;
  logic       acc_inv;
  logic       tracking;
  logic [3:0] exp_digit;
  logic       seq_bad;
  logic       err_inc;

  always_comb begin
    dec_ok    = 1'b1;
    dec_digit = 4'd0;
    case (cand_q)
      7'h3F: dec_digit = 4'd0;
      7'h06: dec_digit = 4'd1;
      7'h5B: dec_digit = 4'd2;
      7'h4F: dec_digit = 4'd3;
      7'h66: dec_digit = 4'd4;
      7'h6D: dec_digit = 4'd5;
      7'h7D: dec_digit = 4'd6;
      7'h07: dec_digit = 4'd7;
      7'h7F: dec_digit = 4'd8;
      7'h6F: dec_digit = 4'd9;
      default: dec_ok = 1'b0;
    endcase
  end

  // One accept per stable pattern: acc_q catches up to cand_q on the event.
  assign accept    = (stab_q == STAB_MAX) && (cand_q != acc_q);
  assign acc_valid = accept && dec_ok;
  assign acc_inv   = accept && !dec_ok;
  assign tracking  = (state_q != IDLE);
  assign exp_digit = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
  assign seq_bad   = acc_valid && tracking && (dec_digit != exp_digit);
  assign err_inc   = seq_bad || acc_inv;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      seg_s_q <= '0;
      cand_q  <= '0;
      stab_q  <= '0;
      acc_q   <= '0;
    end else begin
      sync1_q <= seg_in;
      seg_s_q <= sync1_q;
      if (seg_s_q != cand_q) begin
        cand_q <= seg_s_q;
        stab_q <= '0;
      end else if (stab_q != STAB_MAX) begin
        stab_q <= stab_q + 1'b1;
      end
      if (accept) acc_q <= cand_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      pcnt_q         <= '0;
      digit_q        <= '0;
      digit_valid_q  <= 1'b0;
      new_digit_q    <= 1'b0;
      seq_error_q    <= 1'b0;
      invalid_q      <= 1'b0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
    end else begin
      new_digit_q    <= 1'b0;
      seq_error_q    <= 1'b0;
      invalid_q      <= 1'b0;
      period_valid_q <= 1'b0;
      if (acc_inv) begin
        invalid_q <= 1'b1;
      end else if (acc_valid) begin
        new_digit_q   <= 1'b1;
        digit_q       <= dec_digit;
        digit_valid_q <= 1'b1;
        seq_error_q   <= seq_bad;
        pcnt_q        <= {{(CNT_W-1){1'b0}}, 1'b1};
        unique case (state_q)
          IDLE: begin
            state_q <= FIRST;
          end
          FIRST, TRACK: begin
            period_q       <= pcnt_q;
            period_valid_q <= 1'b1;
            state_q        <= TRACK;
          end
          default: state_q <= IDLE;
        endcase
      end else if (tracking && pcnt_q != CNT_MAX) begin
        pcnt_q <= pcnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clear_errors)
      err_cnt_d = 8'd0;
    else if (err_inc && err_cnt_q != 8'hFF)
      err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign digit           = digit_q;
  assign digit_valid     = digit_valid_q;
  assign new_digit       = new_digit_q;
  assign seq_error       = seq_error_q;
  assign invalid_pattern = invalid_q;
  assign period          = period_q;
  assign period_valid    = period_valid_q;
  assign error_count     = err_cnt_q;

endmodule

// File: tb/tb_seg7_display_monitor.sv
// Directed bench for seg7_display_monitor: pulse counting monitor plus
// immediate-assertion checks in a linear stimulus sequence.
module tb_seg7_display_monitor;

  logic        clk;
  logic        reset;
  logic [6:0]  seg_in;
  logic        clear_errors;
  logic [3:0]  digit;
  logic        digit_valid;
  logic        new_digit;
  logic        seq_error;
  logic        invalid_pattern;
  logic [23:0] period;
  logic        period_valid;
  logic [7:0]  error_count;

  int checks = 0;
  int errors = 0;

  int n_new = 0;
  int n_seq = 0;
  int n_inv = 0;
  int n_pv  = 0;
  logic [3:0] dq[$];
  int         pq[$];

  int b_new, b_seq, b_inv, b_pv, b_dq, b_pq;

  seg7_display_monitor #(
    .STABLE_CYCLES(4),
    .CNT_W(24)
  ) dut (
    .clk(clk),
    .reset(reset),
    .seg_in(seg_in),
    .clear_errors(clear_errors),
    .digit(digit),
    .digit_valid(digit_valid),
    .new_digit(new_digit),
    .seq_error(seq_error),
    .invalid_pattern(invalid_pattern),
    .period(period),
    .period_valid(period_valid),
    .error_count(error_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (new_digit) begin
      n_new = n_new + 1;
      dq.push_back(digit);
    end
    if (seq_error) n_seq = n_seq + 1;
    if (invalid_pattern) n_inv = n_inv + 1;
    if (period_valid) begin
      n_pv = n_pv + 1;
      pq.push_back(int'(period));
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic [6:0] v, input int n);
    seg_in = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    b_new = n_new;
    b_seq = n_seq;
    b_inv = n_inv;
    b_pv  = n_pv;
    b_dq  = dq.size();
    b_pq  = pq.size();
  endtask

  task automatic pulse_clear();
    clear_errors = 1'b1;
    @(posedge clk);
    #1;
    clear_errors = 1'b0;
  endtask

  logic [6:0] pats[0:10];

  initial begin
    pats[0] = 7'h3F; pats[1] = 7'h06; pats[2] = 7'h5B;
    pats[3] = 7'h4F; pats[4] = 7'h66; pats[5] = 7'h6D;
    pats[6] = 7'h7D; pats[7] = 7'h07; pats[8] = 7'h7F;
    pats[9] = 7'h6F; pats[10] = 7'h3F;

    reset = 1'b1;
    seg_in = 7'h00;
    clear_errors = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_digit", int'(digit), 0);
    chk("rst_dvalid", int'(digit_valid), 0);
    chk("rst_errcnt", int'(error_count), 0);
    chk("rst_period", int'(period), 0);

    reset = 1'b0;
    snap();
    hold(7'h00, 50);
    chk("blank_new", n_new - b_new, 0);
    chk("blank_inv", n_inv - b_inv, 0);
    chk("blank_pv", n_pv - b_pv, 0);
    chk("blank_dvalid", int'(digit_valid), 0);
    chk("blank_errcnt", int'(error_count), 0);

    snap();
    for (int i = 0; i < 11; i++) hold(pats[i], 100);
    chk("cnt_new", n_new - b_new, 11);
    chk("cnt_seq", n_seq - b_seq, 0);
    chk("cnt_pv", n_pv - b_pv, 10);
    for (int i = 0; i < 11; i++)
      chk("cnt_digit", int'(dq[b_dq + i]), i % 10);
    for (int i = 0; i < 10; i++)
      chk("cnt_period", pq[b_pq + i], 100);
    chk("cnt_dvalid", int'(digit_valid), 1);
    chk("cnt_errcnt", int'(error_count), 0);

    hold(7'h06, 100);
    chk("to1_digit", int'(digit), 1);
    snap();
    hold(7'h7F, 3);
    hold(7'h06, 50);
    chk("gl3_new", n_new - b_new, 0);
    chk("gl3_seq", n_seq - b_seq, 0);
    chk("gl3_inv", n_inv - b_inv, 0);
    chk("gl3_digit", int'(digit), 1);

    snap();
    hold(7'h7F, 4);
    hold(7'h06, 50);
    chk("gl4_new", n_new - b_new, 2);
    chk("gl4_d8", int'(dq[b_dq]), 8);
    chk("gl4_d1", int'(dq[b_dq + 1]), 1);
    chk("gl4_seq", n_seq - b_seq, 2);
    chk("gl4_inv", n_inv - b_inv, 0);
    chk("gl4_errcnt", int'(error_count), 2);

    pulse_clear();
    chk("clr1_errcnt", int'(error_count), 0);

    hold(7'h5B, 50);
    chk("to2_digit", int'(digit), 2);
    snap();
    hold(7'h11, 10);
    chk("inv_pulse", n_inv - b_inv, 1);
    chk("inv_digit", int'(digit), 2);
    chk("inv_new", n_new - b_new, 0);
    hold(7'h4F, 50);
    chk("after_new", n_new - b_new, 1);
    chk("after_digit", int'(digit), 3);
    chk("after_seq", n_seq - b_seq, 0);
    chk("after_errcnt", int'(error_count), 1);

    snap();
    hold(7'h6D, 50);
    chk("skip_digit", int'(digit), 5);
    chk("skip_seq", n_seq - b_seq, 1);
    chk("skip_errcnt", int'(error_count), 2);

    snap();
    for (int i = 0; i < 300; i++)
      hold((i % 2 == 0) ? 7'h3F : 7'h4F, 10);
    chk("sat_seq", n_seq - b_seq, 300);
    chk("sat_errcnt", int'(error_count), 255);
    pulse_clear();
    chk("clr2_errcnt", int'(error_count), 0);

    hold(7'h07, 50);
    chk("to7_digit", int'(digit), 7);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_dvalid", int'(digit_valid), 0);
    chk("mid_digit", int'(digit), 0);
    snap();
    reset = 1'b0;
    hold(7'h07, 50);
    chk("re_new", n_new - b_new, 1);
    chk("re_digit", int'(digit), 7);
    chk("re_seq", n_seq - b_seq, 0);
    chk("re_pv", n_pv - b_pv, 0);
    chk("re_errcnt", int'(error_count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_display_monitor.md
Name: seg7_display_monitor

Overview:
- Receive-side companion to the seven-segment seconds counter. Watches a 7-bit segment bus driven by a counter/display chip, recovers the displayed digit and checks that the count steps 0..9 with wrap-around.
- Measures the interval between digit changes in clock cycles, so the bench or chip can confirm the counter's compare period.
- Sits on the input pins, e.g. ui_in[6:0] looped back from another tile's uo_out[6:0].

Parameters:
- STABLE_CYCLES, 4, consecutive synchronised cycles a pattern must hold before acceptance; must be ≥1.
- CNT_W, 24, width of the period counter and the period output.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- seg_in  input  7  asynchronous segment bus; bit0=a … bit6=g, active high.
- clear_errors  input  1  synchronous pulse; zeroes error_count.
- digit  output  4  last accepted valid digit, 0..9.
- digit_valid  output  1  high once any valid digit has been accepted.
- new_digit  output  1  one-cycle pulse when a valid digit is accepted.
- seq_error  output  1  one-cycle pulse; accepted digit is not the previous digit +1 mod 10.
- invalid_pattern  output  1  one-cycle pulse; accepted pattern is not a legal digit.
- period  output  CNT_W  cycles between the last two valid acceptances.
- period_valid  output  1  one-cycle pulse when period updates.
- error_count  output  8  count of seq_error plus invalid_pattern events; saturates at 255.

Behaviour:
- Reset: all outputs 0, state IDLE, sync flops 0, candidate 0, accepted pattern 7'h00, stability counter 0, period counter 0.
- Synchroniser: two flops on seg_in give seg_s.
- Stability filter:
  - If seg_s != candidate: candidate <= seg_s, stab <= 0.
  - Otherwise stab increments, saturating at STABLE_CYCLES-1.
  - Accept event fires in the cycle where stab == STABLE_CYCLES-1 and candidate != accepted; accepted <= candidate.
  - At most one event per stable pattern; glitches shorter than STABLE_CYCLES cycles never fire.
- Latency: seg_in change first sampled at edge E0 → output pulse is high in the cycle after edge E0+STABLE_CYCLES+2.
- Decode: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex). All other patterns, including blank 00, are invalid.
- Invalid accept:
  - invalid_pattern pulse; error_count +1.
  - digit, digit_valid, state and period counter unchanged.
  - A later return to the previous valid pattern is a new accept and is sequence-checked.
- Valid accept: new_digit pulse, digit <= d, digit_valid <= 1.
- FSM:
  - IDLE: first valid accept → FIRST. No sequence check, no period output. Period counter <= 1.
  - FIRST or TRACK, valid accept:
    - If d != (digit+1) mod 10: seq_error pulse, error_count +1.
    - period <= period counter; period_valid pulse; period counter <= 1; state → TRACK.
    - Period is reported even on seq_error. Repeating the same digit (e.g. 5→5 via a blank) is a seq_error.
- Period counter: in FIRST/TRACK, increments every non-accept cycle, saturating at 2^CNT_W-1. Accepts at cycles t0 and t1 give period = t1-t0.
- error_count:
  - Saturates at 255.
  - clear_errors sets it to 0; clear wins over a same-cycle increment.
  - seq_error and invalid_pattern are never simultaneous.
- Reset mid-operation: returns to the reset state immediately. An unchanged seg_in holding a nonzero pattern is re-accepted as a fresh first digit, with no seq_error.

Test Plan:
- Reset, seg_in=00 for 50 cycles → no pulses, digit_valid=0, error_count=0.
- Drive 3F, then 06, 5B … 6F, 3F, each held 100 cycles → new_digit ×11, digits 0..9,0, seq_error never. period_valid ×10, each period=100.
- Hold 06, insert a 3-cycle glitch to 7F (STABLE_CYCLES=4) → no pulses. A 4-cycle glitch → invalid_pattern is not raised since 7F is valid; instead new_digit with digit=8 and a seq_error pulse.
- From digit 2 (5B), drive 7'h11 for 10 cycles, then 4F → invalid_pattern pulse, digit stays 2. Then new_digit digit=3, no seq_error, error_count=1.
- Skip digit (4F→6D) → seq_error pulse, error_count increments. 300 skip events → error_count=255. Pulse clear_errors → error_count=0.
- Assert reset while tracking digit 7 with seg_in=07 held → after release, first acceptance of 7 gives new_digit, no seq_error, no period_valid.
